// File: rtl/encoder_8b10b_lanes_pkg.sv
// encoder_8b10b_lanes_pkg: shared 8b/10b code tables, running-disparity encoding and K-code helpers
// Exports: RD_NEG/RD_POS, 6b/4b RD- code tables, K28 6b/4b blocks, alternate-7 block, is_legal_k().
package encoder_8b10b_lanes_pkg;
    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;
    localparam logic [4:0] K28_X = 5'd28;
    localparam logic [5:0] K28_6B_RDN = 6'b001111;
    localparam logic [5:0] D7_6B_RDN = 6'b111000;
    localparam logic [3:0] X3_4B_RDN = 4'b1100;
    localparam logic [3:0] A7_4B_RDN = 4'b0111;
    // abcdei emitted from RD-; the RD+ form is the complement for unbalanced codes and D.7
    localparam logic [5:0] CODE6_RDN [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    // fghj emitted when the 6b block leaves RD-; complemented for unbalanced codes and D.x.3
    localparam logic [3:0] CODE4_RDN [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    // K28 fghj when the 6b block leaves RD-; every K28 4b block flips with RD, balanced or not
    localparam logic [3:0] K28_4B_RDN [8] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
    };
    function automatic logic is_legal_k(input logic [7:0] b);
        return b[4:0] == K28_X || (b[7:5] == 3'd7 &&
            (b[4:0] == 5'd23 || b[4:0] == 5'd27 || b[4:0] == 5'd29 || b[4:0] == 5'd30));
    endfunction
endpackage

// File: rtl/encoder_8b10b_lanes_sym.sv
// encoder_8b10b_lanes_sym: combinational single-symbol 8b/10b encoder with disparity in/out
// Ports: i_byte (HGFEDCBA), i_k (control flag), i_rd (RD before symbol),
//        o_sym (abcdeifghj), o_rd (RD after symbol), o_k_err (illegal K, encoded as data).
module encoder_8b10b_lanes_sym
    import encoder_8b10b_lanes_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_k,
    input  logic       i_rd,
    output logic [9:0] o_sym,
    output logic       o_rd,
    output logic       o_k_err
);
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k_ok;
    logic       w_k28;
    logic       w_a7;
    logic       w_rd6;
    logic       w_flip6;
    logic       w_flip4;
    logic [5:0] w_c6;
    logic [3:0] w_c4;
    assign w_x     = i_byte[4:0];
    assign w_y     = i_byte[7:5];
    assign w_k_ok  = i_k && is_legal_k(i_byte);
    assign w_k28   = w_k_ok && w_x == K28_X;
    assign w_c6    = w_k28 ? K28_6B_RDN : CODE6_RDN[w_x];
    assign w_flip6 = i_rd == RD_POS && ($countones(w_c6) != 3 || w_c6 == D7_6B_RDN);
    assign w_rd6   = $countones(w_c6) == 3 ? i_rd : ~i_rd;
    // A7 avoids a run of five equal bits across the 6b/4b boundary; legal Kx.7 always uses it
    assign w_a7    = w_y == 3'd7 && (w_k_ok ||
                     (w_rd6 == RD_NEG && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                     (w_rd6 == RD_POS && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)));
    assign w_c4    = w_k28 ? K28_4B_RDN[w_y] : w_a7 ? A7_4B_RDN : CODE4_RDN[w_y];
    assign w_flip4 = w_rd6 == RD_POS && (w_k28 || $countones(w_c4) != 2 || w_c4 == X3_4B_RDN);
    assign o_rd    = $countones(w_c4) == 2 ? w_rd6 : ~w_rd6;
    assign o_sym   = {w_flip6 ? ~w_c6 : w_c6, w_flip4 ? ~w_c4 : w_c4};
    assign o_k_err = i_k && !w_k_ok;
endmodule

// File: rtl/encoder_8b10b_lanes.sv
// encoder_8b10b_lanes: registered multi-lane 8b/10b encoder with chained running disparity
// Ports: i_clk, i_reset (sync, active high); input side i_in_valid/o_in_ready, i_in_8b, i_data_k;
//        output side o_out_valid/i_out_ready, o_out_10b, o_code_err, o_rd_out (RD after last lane).
module encoder_8b10b_lanes
    import encoder_8b10b_lanes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [8*LANES-1:0]    i_in_8b,
    input  logic [LANES-1:0]      i_data_k,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [10*LANES-1:0]   o_out_10b,
    output logic [LANES-1:0]      o_code_err,
    output logic                  o_rd_out
);
    logic [LANES:0]        w_rd;
    logic [10*LANES-1:0]   w_sym;
    logic [LANES-1:0]      w_err;
    logic                  w_accept;
    logic                  r_valid;
    logic                  r_rd;
    logic [10*LANES-1:0]   r_sym;
    logic [LANES-1:0]      r_err;
    assign w_rd[0] = r_rd;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        encoder_8b10b_lanes_sym u_sym (
            .i_byte  (i_in_8b[8*g +: 8]),
            .i_k     (i_data_k[g]),
            .i_rd    (w_rd[g]),
            .o_sym   (w_sym[10*g +: 10]),
            .o_rd    (w_rd[g+1]),
            .o_k_err (w_err[g])
        );
    end
    assign o_in_ready = !r_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    // The RD register only advances with an accepted word, so it is also the RD of the held output
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_err   <= '0;
            r_rd    <= RD_NEG;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_sym   <= w_sym;
            r_err   <= w_err;
            r_rd    <= w_rd[LANES];
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign o_out_valid = r_valid;
    assign o_out_10b   = r_sym;
    assign o_code_err  = r_err;
    assign o_rd_out    = r_rd;
endmodule

// File: tb/tb_encoder_8b10b_lanes.sv
// tb_encoder_8b10b_lanes: directed and randomized checks of the lane encoder against a symbol-level model
module tb_encoder_8b10b_lanes;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst;
    logic        v1, rdy1, k1, ov1, ordy1, e1, r1;
    logic [7:0]  d1;
    logic [9:0]  o1;
    logic        v2, rdy2, ov2, ordy2, r2;
    logic [15:0] d2;
    logic [1:0]  k2, e2;
    logic [19:0] o2;
    int n_pass = 0;
    int n_total = 0;
    logic        m_valid, m_rd, acc;
    logic [19:0] m_sym;
    logic [1:0]  m_err;
    logic [11:0] res;

    encoder_8b10b_lanes #(.LANES(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(v1), .o_in_ready(rdy1), .i_in_8b(d1),
        .i_data_k(k1), .o_out_valid(ov1), .i_out_ready(ordy1), .o_out_10b(o1),
        .o_code_err(e1), .o_rd_out(r1)
    );
    encoder_8b10b_lanes #(.LANES(2)) u2 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(v2), .o_in_ready(rdy2), .i_in_8b(d2),
        .i_data_k(k2), .o_out_valid(ov2), .i_out_ready(ordy2), .o_out_10b(o2),
        .o_code_err(e2), .o_rd_out(r2)
    );

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    // K28.y fghj as it appears after 001111 when the symbol starts at RD-
    localparam logic [3:0] K28T [8] = '{
        4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000
    };
    localparam logic [7:0] LEGAL_K [12] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns {code_err, rd_after, symbol}; RD after a symbol follows its overall ones count
    function automatic logic [11:0] ref_enc(input logic [7:0] b, input logic k, input logic rd);
        int x, y, n;
        logic legal, rd6;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] sym;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (legal && x == 28) begin
            sym = rd ? ~{6'b001111, K28T[y]} : {6'b001111, K28T[y]};
        end else begin
            s6 = T6[x];
            if (rd && !($countones(s6) == 3 && s6 != 6'b111000)) s6 = ~s6;
            rd6 = $countones(s6) > 3 ? 1'b1 : $countones(s6) < 3 ? 1'b0 : rd;
            s4 = (y == 7 && (legal || (!rd6 && (x == 17 || x == 18 || x == 20)) ||
                  (rd6 && (x == 11 || x == 13 || x == 14)))) ? 4'b0111 : T4[y];
            if (rd6 && !($countones(s4) == 2 && s4 != 4'b1100)) s4 = ~s4;
            sym = {s6, s4};
        end
        n = $countones(sym);
        return {k && !legal, n > 5 ? 1'b1 : n < 5 ? 1'b0 : rd, sym};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] b, input logic k);
        v1 = 1'b1;
        d1 = b;
        k1 = k;
        tick();
        v1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v1 = 0; d1 = 0; k1 = 0; ordy1 = 1; v2 = 0; d2 = 0; k2 = 0; ordy2 = 1;
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", ov1, 0);
        check("reset out_10b", o1, 0);
        check("reset rd_out", r1, 0);
        check("reset code_err", e1, 0);
        check("reset in_ready", rdy1, 1);
        check("reset out_valid l2", ov2, 0);
        send1(8'hBC, 1);
        check("k28.5 rd- sym", o1, 10'h0FA);
        check("k28.5 rd- rd", r1, 1);
        check("k28.5 valid", ov1, 1);
        send1(8'hBC, 1);
        check("k28.5 rd+ sym", o1, 10'h305);
        check("k28.5 rd+ rd", r1, 0);
        send1(8'h00, 0);
        check("d0.0 sym", o1, 10'h274);
        check("d0.0 rd", r1, 0);
        send1(8'hB5, 0);
        check("d21.5 sym", o1, 10'h2AA);
        check("d21.5 rd", r1, 0);
        send1(8'h00, 1);
        check("illegal k sym", o1, 10'h274);
        check("illegal k err", e1, 1);
        tick();
        check("drain valid", ov1, 0);
        v1 = 1; d1 = 8'hBC; k1 = 1;
        tick();
        check("bp first sym", o1, 10'h0FA);
        ordy1 = 0; d1 = 8'h00; k1 = 0;
        #1;
        check("bp in_ready low", rdy1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp hold sym", o1, 10'h0FA);
            check("bp hold rd", r1, 1);
            check("bp hold valid", ov1, 1);
            check("bp hold ready", rdy1, 0);
        end
        ordy1 = 1;
        #1;
        check("bp release ready", rdy1, 1);
        tick();
        v1 = 0;
        check("bp next sym", o1, 10'h18B);
        check("bp next rd", r1, 1);
        tick();
        check("bp no dup", ov1, 0);
        v1 = 1; d1 = 8'h00; k1 = 0;
        tick();
        check("stall word", ov1, 1);
        v1 = 0; ordy1 = 0; rst = 1;
        tick();
        rst = 0; ordy1 = 1;
        check("stall reset valid", ov1, 0);
        check("stall reset rd", r1, 0);
        check("stall reset sym", o1, 0);
        check("stall reset ready", rdy1, 1);
        send1(8'hBC, 1);
        check("post reset k28.5", o1, 10'h0FA);

        v2 = 1; d2 = 16'h00BC; k2 = 2'b01;
        tick();
        v2 = 0;
        check("l2 chained sym", o2, {10'h18B, 10'h0FA});
        check("l2 chained rd", r2, 1);
        check("l2 chained err", e2, 0);
        m_valid = 1; m_rd = 1; m_sym = {10'h18B, 10'h0FA}; m_err = 0;
        for (int c = 0; c < 600; c++) begin
            v2 = ($urandom_range(9) < 7);
            ordy2 = ($urandom_range(3) != 0);
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(3) == 0) begin
                    d2[8*l +: 8] = LEGAL_K[$urandom_range(11)];
                    k2[l] = 1'b1;
                end else begin
                    d2[8*l +: 8] = 8'($urandom);
                    k2[l] = ($urandom_range(7) == 0);
                end
            end
            #1;
            check("rnd in_ready", rdy2, !m_valid || ordy2);
            acc = v2 && (!m_valid || ordy2);
            if (acc) begin
                res = ref_enc(d2[7:0], k2[0], m_rd);
                m_sym[9:0] = res[9:0];
                m_err[0] = res[11];
                res = ref_enc(d2[15:8], k2[1], res[10]);
                m_sym[19:10] = res[9:0];
                m_err[1] = res[11];
                m_rd = res[10];
                m_valid = 1;
            end else if (ordy2) begin
                m_valid = 0;
            end
            tick();
            check("rnd out_valid", ov2, m_valid);
            if (m_valid) begin
                check("rnd out_10b", o2, m_sym);
                check("rnd code_err", e2, m_err);
                check("rnd rd_out", r2, m_rd);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/encoder_8b10b_lanes.md
# encoder_8b10b_lanes

Clocked, multi-lane 8b/10b encoder with true running-disparity (RD) tracking, control-character validation and a valid/ready handshake. It replaces the combinational single-byte encoder in the PHY transmit path and sits between the link-layer byte stream and the serializer. It accepts LANES bytes per cycle, chains disparity lane 0 → LANES-1, and registers the 10-bit symbols.

## Interface
- LANES, default 1: bytes (symbols) per word, ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_8b  in  8*LANES  lane i = bits [8i+7:8i]; bit 0 = A … bit 7 = H.
- dataK  in  LANES  per-lane control flag (1 = K character).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_10b  out  10*LANES  lane i = [10i+9:10i]; within a lane [9]=a,[8]=b,[7]=c,[6]=d,[5]=e,[4]=i,[3]=f,[2]=g,[1]=h,[0]=j.
- code_err  out  LANES  lane carried an illegal K code (qualified by out_valid).
- rd_out  out  1  RD after the last lane of the current output word (1 = RD+).

## Operation
- Standard 8b/10b: 5b/6b on EDCBA, 3b/4b on HGF, sub-block disparity rules; RD state is one bit, reset value RD− (0).
- Per word: lane 0 encoded with current RD, each lane i+1 uses RD resulting from lane i; RD register updated to final lane's RD only when a word is accepted (in_valid && in_ready).
- D.x.7: use alternate A7 (0111/1000) when (RD− and x ∈ {17,18,20}) or (RD+ and x ∈ {11,13,14}); otherwise P7.
- K characters: legal set K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. K28.y uses 001111/110000 6b block and K-specific 3b/4b (K28.1/.5/.7 contain comma). K x.7 uses A7 form.
- Illegal K (dataK=1, code not in legal set): encode the byte as data D.x.y, set code_err for that lane; RD advances per the data encoding.
- Output register holds out_10b, code_err, rd_out; contents stable while out_valid && !out_ready.

## Timing
- Latency: word accepted in cycle n appears with out_valid=1 in cycle n+1.
- in_ready = !out_valid || out_ready (combinational from out_ready); full throughput 1 word/cycle under continuous out_ready.
- Output register loads on acceptance; out_valid clears when out_ready && !accept.
- Backpressure: while out_valid && !out_ready, in_ready=0, RD frozen, outputs frozen.
- Reset (any cycle, including mid-stream/stalled): next cycle out_valid=0, out_10b=0, code_err=0, rd_out=0, RD=RD−; pending word discarded; in_ready=1 after reset deasserts.
- No combinational path in_8b → out_10b.

## Structure
- Shared package (e.g. `pcie_phy_pkg`): 6b and 4b code constants, K28.5 / legal-K constants, RD encoding (RD_NEG=0, RD_POS=1).
- One natural sub-module: `enc_8b10b_sym` — purely combinational single-symbol encoder (in: byte, K flag, rd_in; out: 10b symbol, rd_out, k_err), instantiated LANES times in a chain; top holds RD register, handshake and output register.

## Test plan
- LANES=1, reset, send K28.5, K28.5 → out_10b 0x0FA then 0x305; rd_out 1 then 0.
- LANES=1 from RD−: D0.0 → 0x274, rd_out 0; D21.5 → 0x2AA (neutral), rd_out unchanged.
- LANES=2, reset, word {lane1=D0.0, lane0=K28.5} → lane0 0x0FA, lane1 0x18B, rd_out 1; chained RD verified.
- Backpressure: out_ready=0 for 3 cycles after first output → in_ready=0, out_10b/rd_out stable, no word lost or duplicated, RD not advanced.
- Illegal K: dataK=1, byte 0x00 (K0.0) → code_err=1, symbol equals D0.0 encoding (0x274 from RD−).
- Reset asserted while out_valid=1 && out_ready=0 → next cycle out_valid=0, rd_out=0; next K28.5 encodes as 0x0FA.
